// File: rtl/sensor_acq_sequencer.sv
// Per-trigger sequencer: staggered start pulses to enabled sensors, done-edge capture, watchdog and status.
// Latency: first start pulse 2 cycles after trigger; trigger while busy is dropped and flagged as overrun.
module sensor_acq_sequencer #(
    parameter int N_SENSORS = 10,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic [N_SENSORS-1:0] en_bits,
    input  logic [CNT_W-1:0]     stagger,
    input  logic [CNT_W-1:0]     timeout,
    input  logic [N_SENSORS-1:0] done_in,
    input  logic                 clear_overrun,
    output logic [N_SENSORS-1:0] start_out,
    output logic                 busy,
    output logic                 seq_done,
    output logic                 all_done,
    output logic [N_SENSORS-1:0] timeout_flags,
    output logic [CNT_W-1:0]     seq_cycles,
    output logic                 overrun
);

    localparam int IDX_W = $clog2(N_SENSORS + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

    state_t               state_q;
    logic [N_SENSORS-1:0] en_lat_q;
    logic [N_SENSORS-1:0] started_q;
    logic [N_SENSORS-1:0] done_lat_q;
    logic [N_SENSORS-1:0] done_in_q;
    logic [CNT_W-1:0]     gap_q;
    logic [CNT_W-1:0]     elapsed_q;
    logic [CNT_W-1:0]     stagger_lat_q;
    logic [CNT_W-1:0]     timeout_lat_q;
    logic [IDX_W-1:0]     idx_q;

    logic [N_SENSORS-1:0] start_out_q;
    logic                 busy_q;
    logic                 seq_done_q;
    logic                 all_done_q;
    logic [N_SENSORS-1:0] timeout_flags_q;
    logic [CNT_W-1:0]     seq_cycles_q;
    logic                 overrun_q;

    logic [N_SENSORS-1:0] done_lat_d;
    logic [CNT_W-1:0]     elapsed_d;
    logic [N_SENSORS-1:0] cand;
    logic [N_SENSORS-1:0] pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 wd_expired;
    logic                 go_finish;

    always_comb begin
        // Done edges only count for slots that have already been started.
        done_lat_d = done_lat_q | (done_in & ~done_in_q & started_q);
        elapsed_d  = (&elapsed_q) ? elapsed_q : elapsed_q + CNT_W'(1);
        wd_expired = (timeout_lat_q != '0) && (elapsed_q == timeout_lat_q);
        go_finish  = ((state_q == LAUNCH) || (state_q == WAIT)) &&
                     (wd_expired || ((state_q == WAIT) && (done_lat_q == en_lat_q)));

        cand     = '0;
        pick     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            cand[i] = en_lat_q[i] & ~started_q[i] & (IDX_W'(i) >= idx_q);
        end
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick     = '0;
                pick[i]  = 1'b1;
                pick_idx = IDX_W'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            en_lat_q        <= '0;
            started_q       <= '0;
            done_lat_q      <= '0;
            done_in_q       <= '0;
            gap_q           <= '0;
            elapsed_q       <= '0;
            stagger_lat_q   <= '0;
            timeout_lat_q   <= '0;
            idx_q           <= '0;
            start_out_q     <= '0;
            busy_q          <= 1'b0;
            seq_done_q      <= 1'b0;
            all_done_q      <= 1'b0;
            timeout_flags_q <= '0;
            seq_cycles_q    <= '0;
            overrun_q       <= 1'b0;
        end else begin
            start_out_q <= '0;
            seq_done_q  <= 1'b0;
            done_in_q   <= done_in;

            if (trigger && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (trigger && (en_bits != '0)) begin
                        state_q         <= LAUNCH;
                        busy_q          <= 1'b1;
                        en_lat_q        <= en_bits;
                        started_q       <= '0;
                        done_lat_q      <= '0;
                        timeout_flags_q <= '0;
                        all_done_q      <= 1'b0;
                        elapsed_q       <= '0;
                        idx_q           <= '0;
                        gap_q           <= '0;
                        stagger_lat_q   <= stagger;
                        timeout_lat_q   <= timeout;
                    end
                end
                LAUNCH, WAIT: begin
                    done_lat_q <= done_lat_d;
                    elapsed_q  <= elapsed_d;
                    if (go_finish) begin
                        state_q      <= FINISH;
                        seq_done_q   <= 1'b1;
                        seq_cycles_q <= elapsed_d;
                        all_done_q   <= (done_lat_d == en_lat_q);
                        if (wd_expired) begin
                            timeout_flags_q <= en_lat_q & ~done_lat_d;
                        end
                    end else if (state_q == LAUNCH) begin
                        if (gap_q != '0) begin
                            gap_q <= gap_q - CNT_W'(1);
                        end else if (pick_vld) begin
                            start_out_q <= pick;
                            started_q   <= started_q | pick;
                            idx_q       <= pick_idx + IDX_W'(1);
                            gap_q       <= stagger_lat_q;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_out     = start_out_q;
    assign busy          = busy_q;
    assign seq_done      = seq_done_q;
    assign all_done      = all_done_q;
    assign timeout_flags = timeout_flags_q;
    assign seq_cycles    = seq_cycles_q;
    assign overrun       = overrun_q;

endmodule
